// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with valid/ready input and a fixed clocks-per-bit divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_done = (bit_cnt == CNT_MAX);

    // NOTE: tx_ready is combinational so it drops in the same cycle rst is raised,
    // letting no handshake complete on a reset edge.
    assign tx_ready = (state == IDLE) && !rst;
    assign tx_busy  = (state != IDLE);

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // pre-edge values of shift/bit_idx/bit_cnt regardless of statement order.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    if (tx_valid) begin
                        shift      <= tx_data;
                        bit_idx    <= '0;
                        tx         <= 1'b0;
                        state      <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end

                START: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // Register the next bit now so the line changes exactly at the boundary.
                            tx <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif

                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; frame layout follows UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int T_CLK = 10;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int n_vec = 0;
    int n_err = 0;

    always #(T_CLK / 2) clock = ~clock;

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clock   (clock),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Entered at a negedge with tx_valid/tx_data already driven; returns at the
    // negedge of the cycle in which IDLE is re-entered.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic hold,
                             input int inject, output time fall);
        logic [NB-1:0] exp_bits;
        logic [N-1:0]  smp;
        logic [7:0]    got;
        logic          busy_all;
        logic          ready_any;
`ifdef UART_TX_PARITY_EN
        exp_bits = {1'b1, ^data, data, 1'b0};
`else
        exp_bits = {1'b1, data, 1'b0};
`endif
        busy_all  = 1'b1;
        ready_any = 1'b0;
        got       = 8'h00;
        smp       = '0;
        @(posedge clock);
        fall = $time;
        if (!hold) begin
            #1 tx_valid = 1'b0;
        end
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < N; k++) begin
                @(negedge clock);
                smp[k]    = tx;
                busy_all  = busy_all & tx_busy;
                ready_any = ready_any | tx_ready;
                if (b * N + k == inject) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'hFF;
                end else if (b * N + k == inject + 1) begin
                    tx_valid = 1'b0;
                end
            end
            check($sformatf("%s bit%0d", tag, b), 32'(smp), 32'({N{exp_bits[b]}}));
            if (b >= 1 && b <= 8) got[b-1] = smp[N/2];
        end
        check($sformatf("%s decoded", tag), 32'(got), 32'(data));
        check($sformatf("%s busy_all_frame", tag), 32'(busy_all), 32'd1);
        check($sformatf("%s ready_in_frame", tag), 32'(ready_any), 32'd0);
        @(negedge clock);
        check($sformatf("%s idle_ready", tag), 32'(tx_ready), 32'd1);
        check($sformatf("%s idle_busy", tag), 32'(tx_busy), 32'd0);
        check($sformatf("%s idle_tx", tag), 32'(tx), 32'd1);
    endtask

    initial begin
        time f1;
        time f2;
        logic all_high;

        // Reset held for 3 cycles
        repeat (3) @(negedge clock);
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clock);
        check("post_rst ready", 32'(tx_ready), 32'd1);
        check("post_rst tx", 32'(tx), 32'd1);

        // 0x55: alternating line levels
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        run_frame("b55", 8'h55, 1'b0, -10, f1);

        // Back-to-back with tx_valid held: start bits NB*N+1 cycles apart
        tx_data  = 8'h80;
        tx_valid = 1'b1;
        run_frame("b80", 8'h80, 1'b1, -10, f1);
        tx_data = 8'h01;
        run_frame("b01", 8'h01, 1'b0, -10, f2);
        check("b2b period", 32'(f2 - f1), 32'((NB * N + 1) * T_CLK));

        // 0x00 with an 0xFF request and data change mid-frame
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        run_frame("b00_ign", 8'h00, 1'b0, 10, f1);
        repeat (2) @(negedge clock);
        check("no_queue tx", 32'(tx), 32'd1);
        check("no_queue busy", 32'(tx_busy), 32'd0);

        // Reset during data bit 3 of 0xA5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clock);
        #1 tx_valid = 1'b0;
        repeat (17) @(negedge clock);
        check("a5 bit3 pre_rst", 32'(tx), 32'd0);
        rst = 1'b1;
        @(negedge clock);
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst busy", 32'(tx_busy), 32'd0);
        check("midrst ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clock);
        check("midrst release ready", 32'(tx_ready), 32'd1);
        all_high = 1'b1;
        for (int i = 0; i < 5 * N; i++) begin
            @(negedge clock);
            all_high = all_high & tx & !tx_busy;
        end
        check("midrst abandoned", 32'(all_high), 32'd1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        run_frame("b3c", 8'h3C, 1'b0, -10, f1);

`ifdef UART_TX_PARITY_EN
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        run_frame("par07", 8'h07, 1'b0, -10, f1);
        tx_data  = 8'h03;
        tx_valid = 1'b1;
        run_frame("par03", 8'h03, 1'b0, -10, f1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
